// File: rtl/noc_arbiter_pkg.sv
// Shared constants and helpers for the NoC output-port round-robin arbiter.
// Port index order: N, E, W, S, L; wider routers append extra ports after L.
package noc_arbiter_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  localparam int DEFAULT_NUM_PORTS = 5;
  localparam int GRANT_CNT_W       = 16;

  // OR-reduction form keeps this a flat mux-free encoder for a one-hot input.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first set bit of req scanning cyclically from start.
// Zero latency, no flow control; with exclude_first the start position is checked last.
module rr_pick #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  input  logic                 exclude_first,
  output logic [NUM_PORTS-1:0] pick
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pos = IDX_W'((int'(start) + k + (exclude_first ? 1 : 0)) % NUM_PORTS);
      if (!found && req[pos]) begin
        pick[pos] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_arbiter_rr.sv
// Round-robin output-port arbiter with burst-limited ownership and RTS/DCTS handshake; first grant 2 cycles after req.
// Owner is frozen while rts waits for dcts. NOC_ARB_GRANT_CNT_EN adds per-port saturating grant counters on grant_cnt.
module noc_arbiter_rr
  import noc_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
`ifdef NOC_ARB_GRANT_CNT_EN
  ,output logic [NUM_PORTS*GRANT_CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int BW    = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  logic [NUM_PORTS-1:0] state, state_next, pick;
  logic                 rts_next;
  logic [IDX_W-1:0]     last_owner, owner_idx, start;
  logic [BW-1:0]        burst_cnt;
  logic                 idle, other_req, keep;

  assign idle      = (state == '0);
  assign owner_idx = IDX_W'(onehot_to_idx(32'(state)));
  assign other_req = |(req & ~state);
  assign start     = idle ? last_owner : owner_idx;
  assign keep      = (|(req & state)) &&
                     (MAX_BURST == 0 || int'(burst_cnt) < MAX_BURST || !other_req);

  rr_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .req          (req),
    .start        (start),
    .exclude_first(1'b1),
    .pick         (pick)
  );

  always_comb begin
    state_next = pick;
    rts_next   = !idle && !(rts && dcts);
    if (rts && !dcts) begin
      state_next = state;
    end else if (!idle && keep) begin
      state_next = state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= '0;
      rts        <= 1'b0;
      last_owner <= IDX_W'(NUM_PORTS - 2);
      burst_cnt  <= '0;
    end else begin
      state <= state_next;
      rts   <= rts_next;
      if (state_next != state) begin
        burst_cnt <= '0;
        if (!idle) last_owner <= owner_idx;
      end else if (MAX_BURST != 0 && rts && dcts && int'(burst_cnt) < MAX_BURST) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign grant    = state & {NUM_PORTS{rts & dcts}};
  assign xbar_sel = state;

`ifdef NOC_ARB_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt [NUM_PORTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (grant[i] && cnt[i] != '1) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign grant_cnt[g*GRANT_CNT_W +: GRANT_CNT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_noc_arbiter_rr.sv
// Directed and random stimulus for noc_arbiter_rr (MAX_BURST=2) against a rule-level reference model.
module tb_noc_arbiter_rr;

  localparam int N  = 5;
  localparam int MB = 2;

  logic         clk, rst, dcts, rts;
  logic [N-1:0] req, grant, xbar_sel;
`ifdef NOC_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  noc_arbiter_rr #(.NUM_PORTS(N), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .dcts    (dcts),
    .grant   (grant),
    .xbar_sel(xbar_sel),
    .rts     (rts)
`ifdef NOC_ARB_GRANT_CNT_EN
    ,.grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner as an integer (-1 = idle), plus handshake flag, last owner, burst count.
  int m_owner = -1;
  bit m_rts   = 1'b0;
  int m_last  = N - 2;
  int m_burst = 0;
  int m_cnt [N];

  function automatic int m_find(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_sel();
    return (m_owner < 0) ? '0 : N'(1 << m_owner);
  endfunction

  function automatic logic [N-1:0] m_grant(input logic d);
    return (m_rts && d) ? m_sel() : '0;
  endfunction

  function automatic int gidx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int  nxt;
    bit  nrts;
    bit  others;
    if (rst) begin
      m_owner = -1; m_rts = 0; m_last = N - 2; m_burst = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    if (m_rts && dcts && m_owner >= 0 && m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
    if (m_rts && !dcts) begin
      nxt = m_owner;
    end else if (m_owner < 0) begin
      nxt = m_find(req, m_last);
    end else begin
      others = (req & ~N'(1 << m_owner)) != '0;
      if (req[m_owner] && (MB == 0 || m_burst < MB || !others)) nxt = m_owner;
      else nxt = m_find(req, m_owner);
    end
    nrts = (m_owner >= 0) && !(m_rts && dcts);
    if (nxt != m_owner) begin
      m_burst = 0;
      if (m_owner >= 0) m_last = m_owner;
    end else if (m_rts && dcts && m_burst < MB) begin
      m_burst++;
    end
    m_owner = nxt;
    m_rts   = nrts;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model with the inputs seen at the edge, compare all outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("model_grant", 32'(grant), 32'(m_grant(dcts)));
    chk("model_xbar",  32'(xbar_sel), 32'(m_sel()));
    chk("model_rts",   32'(rts), 32'(m_rts));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  int q[$];
  int seq_all[10] = '{4, 4, 0, 0, 1, 1, 2, 2, 3, 3};
  int seq_ns[8]   = '{0, 0, 3, 3, 0, 0, 3, 3};
  int n_grants;
  bit only_n;

  initial begin
    rst = 1'b1; req = '0; dcts = 1'b1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;

    // Reset then a single W requester.
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_xbar", 32'(xbar_sel), 0);
    chk("rst_rts", 32'(rts), 0);
    rst = 1'b0; req = 5'b00100;
    tick();
    chk("w_c1_xbar", 32'(xbar_sel), 32'h04);
    chk("w_c1_rts", 32'(rts), 0);
    tick();
    chk("w_c2_rts", 32'(rts), 1);
    chk("w_c2_grant", 32'(grant), 32'h04);
    tick();
    chk("w_c3_rts", 32'(rts), 0);
    for (int i = 0; i < 6; i++) tick();
    req = '0;
    for (int i = 0; i < 4; i++) tick();

    // All ports request from idle: L first, then rotation in pairs.
    do_reset();
    req = 5'b11111;
    tick();
    chk("all_first_owner", 32'(xbar_sel), 32'h10);
    q.delete();
    for (int i = 0; i < 22; i++) begin
      tick();
      if (grant != '0) q.push_back(gidx(grant));
    end
    chk("all_seq_len", 32'(q.size() >= 10), 1);
    for (int i = 0; i < 10 && i < q.size(); i++) chk("all_seq", 32'(q[i]), 32'(seq_all[i]));

    // Backpressure: owner E waiting on dcts while requests move to L.
    do_reset();
    req = 5'b00010; dcts = 1'b0;
    tick();
    tick();
    chk("bp_rts_up", 32'(rts), 1);
    req = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_xbar", 32'(xbar_sel), 32'h02);
      chk("bp_hold_rts", 32'(rts), 1);
      chk("bp_hold_grant", 32'(grant), 0);
    end
    dcts = 1'b1;
    #1;
    chk("bp_release_grant", 32'(grant), 32'h02);
    tick();
    chk("bp_new_owner", 32'(xbar_sel), 32'h10);
    chk("bp_new_rts", 32'(rts), 0);

    // Burst limit between N and S, then N alone keeps ownership.
    do_reset();
    req = 5'b01001;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant != '0) q.push_back(gidx(grant));
    end
    chk("burst_len", 32'(q.size() >= 8), 1);
    for (int i = 0; i < 8 && i < q.size(); i++) chk("burst_seq", 32'(q[i]), 32'(seq_ns[i]));
    req = 5'b00001;
    n_grants = 0; only_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant != '0) begin
        n_grants++;
        if (grant != 5'b00001) only_n = 1'b0;
      end
    end
    chk("n_alone_only_n", 32'(only_n), 1);
    chk("n_alone_count", 32'(n_grants >= 9), 1);

    // Reset in the middle of a stalled handshake.
    do_reset();
    req = 5'b00100; dcts = 1'b0;
    tick();
    tick();
    chk("mid_rts_up", 32'(rts), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_rts", 32'(rts), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_xbar", 32'(xbar_sel), 0);
    rst = 1'b0; req = 5'b00001; dcts = 1'b1;
    tick();
    chk("mid_new_owner", 32'(xbar_sel), 32'h01);

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 31));
      dcts = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
      chk("onehot_grant", 32'($countones(grant) <= 1), 1);
    end
    rst = 1'b0;

`ifdef NOC_ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 32'(grant_cnt[16*i +: 16]), 32'(m_cnt[i]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
